video_serial_rx: RTL and testbench

VIDEO_SERIAL_RX -- requirements
Module: video_serial_rx

---
 rtl/video_serial_pkg.sv | 22 ++
 rtl/serial_word_rx.sv | 95 +++++++++
 rtl/video_serial_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_video_serial_rx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_serial_pkg.sv
// Shared opcodes, decoder state encoding and window helper for the serial
// video receiver.
package video_serial_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CASET = 3'd1,
    ST_RASET = 3'd2,
    ST_RAMWR = 3'd3,
    ST_SKIP  = 3'd4
  } dec_state_e;

  // An inverted window collapses to a single line at its start.
  function automatic logic [15:0] win_end(input logic [15:0] s, input logic [15:0] e);
    return (s > e) ? s : e;
  endfunction

endpackage

// File: rtl/serial_word_rx.sv
// Serial front end: synchronizes the panel bus into clk_i, detects serial
// clock rising edges and assembles MSB-first words with their D/C flag.
module serial_word_rx #(
  parameter int SERIAL_BITS = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   srst_i,
  input  logic                   sclk_i,
  input  logic                   sdata_i,
  input  logic                   sel_i,
  input  logic                   dc_i,
  output logic                   word_valid_o,
  output logic [SERIAL_BITS-1:0] word_o,
  output logic                   word_dc_o
);

  localparam int CW = $clog2(SERIAL_BITS + 1);

  // Bit order in the sync vectors: [3] sclk, [2] data, [1] select, [0] D/C.
  logic [3:0]             sync1_q, sync2_q;
  logic                   sclk_prev_q;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SERIAL_BITS-1:0] shift_q, shift_d;
  logic [SERIAL_BITS-1:0] word_q, word_d;
  logic                   word_valid_q, word_valid_d;
  logic                   dc_q, dc_d;
  logic                   rise_s;

  // Synchronizer chain; panel reset leaves it alone so no false edge appears on release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 4'b0000;
      sync2_q     <= 4'b0000;
      sclk_prev_q <= 1'b0;
    end else begin
      sync1_q     <= {sclk_i, sdata_i, sel_i, dc_i};
      sync2_q     <= sync1_q;
      sclk_prev_q <= sync2_q[3];
    end
  end

  assign rise_s = sync2_q[3] & ~sclk_prev_q;

  // Shift register and bit counter next state.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    dc_d         = dc_q;
    if (srst_i) begin
      bit_cnt_d = '0;
      shift_d   = '0;
      word_d    = '0;
      dc_d      = 1'b0;
    end else if (!sync2_q[1]) begin
      bit_cnt_d = '0;
    end else if (rise_s) begin
      shift_d = {shift_q[SERIAL_BITS-2:0], sync2_q[2]};
      if (bit_cnt_q == CW'(SERIAL_BITS - 1)) begin
        bit_cnt_d    = '0;
        word_valid_d = 1'b1;
        word_d       = shift_d;
        dc_d         = sync2_q[0];
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Word assembly registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      dc_q         <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      dc_q         <= dc_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;
  assign word_dc_o    = dc_q;

endmodule

// File: rtl/video_serial_rx.sv
// Panel-controller style receiver: decodes CASET/RASET/RAMWR from the serial
// word stream and emits pixel writes with visible-area coordinates.
module video_serial_rx
  import video_serial_pkg::*;
#(
  parameter int SERIAL_BITS   = 8,
  parameter int PIXEL_BITS    = 16,
  parameter int SCREEN_WIDTH  = 240,
  parameter int SCREEN_HEIGHT = 135,
  parameter int SCREEN_HOFFS  = 40,
  parameter int SCREEN_VOFFS  = 55
) (
  input  logic                             in_clk,
  input  logic                             in_rst,
  input  logic                             in_vid_rst,
  input  logic                             in_vid_select,
  input  logic                             in_vid_cmd,
  input  logic                             in_vid_serial_clk,
  input  logic                             in_vid_serial,
  output logic                             out_cmd_valid,
  output logic [7:0]                       out_cmd,
  output logic                             out_pix_valid,
  output logic [PIXEL_BITS-1:0]            out_pixel,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  out_hpix,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] out_vpix,
  output logic                             out_frame
);

  localparam int          HW       = $clog2(SCREEN_WIDTH);
  localparam int          VW       = $clog2(SCREEN_HEIGHT);
  localparam int          PB_BYTES = PIXEL_BITS / 8;
  localparam logic [15:0] X_OFF    = 16'(SCREEN_HOFFS);
  localparam logic [15:0] Y_OFF    = 16'(SCREEN_VOFFS);
  localparam logic [15:0] X_LIM    = 16'(SCREEN_HOFFS + SCREEN_WIDTH);
  localparam logic [15:0] Y_LIM    = 16'(SCREEN_VOFFS + SCREEN_HEIGHT);
  localparam logic [15:0] XE_RST   = 16'(SCREEN_HOFFS + SCREEN_WIDTH - 1);
  localparam logic [15:0] YE_RST   = 16'(SCREEN_VOFFS + SCREEN_HEIGHT - 1);

  logic                   word_valid_s, word_dc_s;
  logic [SERIAL_BITS-1:0] word_s;
  logic [7:0]             byte_s;

  serial_word_rx #(.SERIAL_BITS(SERIAL_BITS)) u_word_rx (
    .clk_i        (in_clk),
    .rst_ni       (in_rst),
    .srst_i       (in_vid_rst),
    .sclk_i       (in_vid_serial_clk),
    .sdata_i      (in_vid_serial),
    .sel_i        (in_vid_select),
    .dc_i         (in_vid_cmd),
    .word_valid_o (word_valid_s),
    .word_o       (word_s),
    .word_dc_o    (word_dc_s)
  );

  assign byte_s = word_s[7:0];

  dec_state_e            state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           par_q, par_d;
  logic [15:0]           xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [15:0]           x_q, x_d, y_q, y_d;
  logic [PIXEL_BITS-1:0] pix_q, pix_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [7:0]            cmd_q, cmd_d;
  logic                  pix_valid_q, pix_valid_d;
  logic [PIXEL_BITS-1:0] pixel_q, pixel_d;
  logic [HW-1:0]         hpix_q, hpix_d;
  logic [VW-1:0]         vpix_q, vpix_d;
  logic                  frame_q, frame_d;
  logic [15:0]           xe_eff_s, ye_eff_s;
  logic [PIXEL_BITS-1:0] pixel_s;
  logic                  visible_s;

  assign xe_eff_s  = win_end(xs_q, xe_q);
  assign ye_eff_s  = win_end(ys_q, ye_q);
  assign pixel_s   = {pix_q[PIXEL_BITS-9:0], byte_s};
  assign visible_s = (x_q >= X_OFF) && (x_q < X_LIM) && (y_q >= Y_OFF) && (y_q < Y_LIM);

  // Decoder FSM, window capture and address stepping.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    par_d       = par_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_d       = pix_q;
    cmd_valid_d = 1'b0;
    cmd_d       = cmd_q;
    pix_valid_d = 1'b0;
    pixel_d     = pixel_q;
    hpix_d      = hpix_q;
    vpix_d      = vpix_q;
    frame_d     = 1'b0;
    if (in_vid_rst) begin
      state_d    = ST_IDLE;
      byte_cnt_d = 2'd0;
      par_d      = 24'd0;
      xs_d       = X_OFF;
      xe_d       = XE_RST;
      ys_d       = Y_OFF;
      ye_d       = YE_RST;
      x_d        = 16'd0;
      y_d        = 16'd0;
      pix_d      = '0;
      cmd_d      = 8'd0;
      pixel_d    = '0;
      hpix_d     = '0;
      vpix_d     = '0;
    end else if (word_valid_s && word_dc_s) begin
      cmd_valid_d = 1'b1;
      cmd_d       = byte_s;
      byte_cnt_d  = 2'd0;
      case (byte_s)
        CMD_CASET: state_d = ST_CASET;
        CMD_RASET: state_d = ST_RASET;
        CMD_RAMWR: begin
          state_d = ST_RAMWR;
          x_d     = xs_q;
          y_d     = ys_q;
        end
        default:   state_d = ST_SKIP;
      endcase
    end else if (word_valid_s) begin
      case (state_q)
        ST_CASET, ST_RASET: begin
          if (byte_cnt_q == 2'd3) begin
            state_d    = ST_IDLE;
            byte_cnt_d = 2'd0;
            if (state_q == ST_CASET) begin
              xs_d = par_q[23:8];
              xe_d = {par_q[7:0], byte_s};
            end else begin
              ys_d = par_q[23:8];
              ye_d = {par_q[7:0], byte_s};
            end
          end else begin
            par_d      = {par_q[15:0], byte_s};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
        ST_RAMWR: begin
          if (byte_cnt_q == 2'(PB_BYTES - 1)) begin
            byte_cnt_d  = 2'd0;
            pixel_d     = pixel_s;
            pix_valid_d = visible_s;
            hpix_d      = HW'(x_q - X_OFF);
            vpix_d      = VW'(y_q - Y_OFF);
            if (x_q >= xe_eff_s) begin
              x_d = xs_q;
              if (y_q >= ye_eff_s) begin
                y_d     = ys_q;
                frame_d = 1'b1;
              end else begin
                y_d = y_q + 16'd1;
              end
            end else begin
              x_d = x_q + 16'd1;
            end
          end else begin
            pix_d      = pixel_s;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Decoder and output registers.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= 2'd0;
      par_q       <= 24'd0;
      xs_q        <= X_OFF;
      xe_q        <= XE_RST;
      ys_q        <= Y_OFF;
      ye_q        <= YE_RST;
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      pix_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= 8'd0;
      pix_valid_q <= 1'b0;
      pixel_q     <= '0;
      hpix_q      <= '0;
      vpix_q      <= '0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      par_q       <= par_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_q       <= pix_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      pix_valid_q <= pix_valid_d;
      pixel_q     <= pixel_d;
      hpix_q      <= hpix_d;
      vpix_q      <= vpix_d;
      frame_q     <= frame_d;
    end
  end

  assign out_cmd_valid = cmd_valid_q;
  assign out_cmd       = cmd_q;
  assign out_pix_valid = pix_valid_q;
  assign out_pixel     = pixel_q;
  assign out_hpix      = hpix_q;
  assign out_vpix      = vpix_q;
  assign out_frame     = frame_q;

endmodule

// File: tb/tb_video_serial_rx.sv
// Directed and randomized bench for video_serial_rx, checked against a
// byte-level model of the panel command protocol.
module tb_video_serial_rx;

  localparam int W  = 240;
  localparam int H  = 135;
  localparam int HO = 40;
  localparam int VO = 55;

  logic        in_clk = 1'b0;
  logic        in_rst, in_vid_rst, in_vid_select, in_vid_cmd;
  logic        in_vid_serial_clk, in_vid_serial;
  logic        out_cmd_valid, out_pix_valid, out_frame;
  logic [7:0]  out_cmd, out_hpix, out_vpix;
  logic [15:0] out_pixel;

  video_serial_rx dut (
    .in_clk            (in_clk),
    .in_rst            (in_rst),
    .in_vid_rst        (in_vid_rst),
    .in_vid_select     (in_vid_select),
    .in_vid_cmd        (in_vid_cmd),
    .in_vid_serial_clk (in_vid_serial_clk),
    .in_vid_serial     (in_vid_serial),
    .out_cmd_valid     (out_cmd_valid),
    .out_cmd           (out_cmd),
    .out_pix_valid     (out_pix_valid),
    .out_pixel         (out_pixel),
    .out_hpix          (out_hpix),
    .out_vpix          (out_vpix),
    .out_frame         (out_frame)
  );

  always #5 in_clk = ~in_clk;

  typedef struct packed {
    logic        v;
    logic [15:0] pix;
    logic [7:0]  h;
    logic [7:0]  vv;
    logic        f;
  } pev_t;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] obs_cmd[$];
  logic [7:0] exp_cmd[$];
  pev_t       obs_pix[$];
  pev_t       exp_pix[$];

  // Event capture away from the active edge.
  always @(negedge in_clk) begin
    pev_t e;
    if (in_rst && out_cmd_valid) obs_cmd.push_back(out_cmd);
    if (in_rst && (out_pix_valid || out_frame)) begin
      e = {out_pix_valid, out_pixel, out_hpix, out_vpix, out_frame};
      obs_pix.push_back(e);
    end
  end

  // Protocol model: mode 0 idle, 1 column set, 2 row set, 3 memory write, 4 skip.
  int m_mode, m_xs, m_xe, m_ys, m_ye, m_x, m_y;
  int m_par[$];
  int m_pb[$];

  task automatic model_reset();
    m_mode = 0;
    m_xs = HO; m_xe = HO + W - 1;
    m_ys = VO; m_ye = VO + H - 1;
    m_par.delete();
    m_pb.delete();
  endtask

  task automatic model_byte(input bit dc, input int b);
    pev_t e;
    int   xend, yend, pix;
    bit   vis, fr;
    if (dc) begin
      exp_cmd.push_back(8'(b));
      m_par.delete();
      m_pb.delete();
      if (b == 'h2A) m_mode = 1;
      else if (b == 'h2B) m_mode = 2;
      else if (b == 'h2C) begin m_mode = 3; m_x = m_xs; m_y = m_ys; end
      else m_mode = 4;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_par.push_back(b);
      if (m_par.size() == 4) begin
        if (m_mode == 1) begin m_xs = m_par[0]*256 + m_par[1]; m_xe = m_par[2]*256 + m_par[3]; end
        else begin m_ys = m_par[0]*256 + m_par[1]; m_ye = m_par[2]*256 + m_par[3]; end
        m_par.delete();
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      m_pb.push_back(b);
      if (m_pb.size() == 2) begin
        pix = m_pb[0]*256 + m_pb[1];
        m_pb.delete();
        vis = (m_x >= HO) && (m_x < HO + W) && (m_y >= VO) && (m_y < VO + H);
        e.v = vis; e.pix = 16'(pix); e.h = 8'(m_x - HO); e.vv = 8'(m_y - VO);
        xend = (m_xs > m_xe) ? m_xs : m_xe;
        yend = (m_ys > m_ye) ? m_ys : m_ye;
        fr = 1'b0;
        if (m_x == xend) begin
          m_x = m_xs;
          if (m_y == yend) begin m_y = m_ys; fr = 1'b1; end
          else m_y = m_y + 1;
        end else begin
          m_x = m_x + 1;
        end
        e.f = fr;
        if (vis || fr) exp_pix.push_back(e);
      end
    end
  endtask

  task automatic send_bits(input bit dc, input logic [7:0] b, input int nbits);
    in_vid_cmd = dc;
    for (int i = 0; i < nbits; i++) begin
      in_vid_serial = b[7-i];
      #20 in_vid_serial_clk = 1'b1;
      #20 in_vid_serial_clk = 1'b0;
    end
    #20;
  endtask

  task automatic send_byte(input bit dc, input int b);
    send_bits(dc, 8'(b), 8);
    model_byte(dc, b);
  endtask

  task automatic send_win(input int cmd, input int s, input int e);
    send_byte(1'b1, cmd);
    send_byte(1'b0, (s >> 8) & 255);
    send_byte(1'b0, s & 255);
    send_byte(1'b0, (e >> 8) & 255);
    send_byte(1'b0, e & 255);
  endtask

  task automatic send_pixels(input int n);
    int p;
    send_byte(1'b1, 'h2C);
    for (int i = 0; i < n; i++) begin
      p = $urandom_range(0, 65535);
      send_byte(1'b0, p >> 8);
      send_byte(1'b0, p & 255);
    end
  endtask

  task automatic check_events(input string tag);
    int n;
    repeat (12) @(negedge in_clk);
    n_cmp++;
    assert (obs_cmd.size() === exp_cmd.size()) else begin
      n_err++;
      $error("FAIL %s cmd_count: got %0d expected %0d", tag, obs_cmd.size(), exp_cmd.size());
    end
    n = (obs_cmd.size() < exp_cmd.size()) ? obs_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      assert (obs_cmd[i] === exp_cmd[i]) else begin
        n_err++;
        $error("FAIL %s cmd[%0d]: got %h expected %h", tag, i, obs_cmd[i], exp_cmd[i]);
      end
    end
    n_cmp++;
    assert (obs_pix.size() === exp_pix.size()) else begin
      n_err++;
      $error("FAIL %s pix_count: got %0d expected %0d", tag, obs_pix.size(), exp_pix.size());
    end
    n = (obs_pix.size() < exp_pix.size()) ? obs_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      assert ({obs_pix[i].v, obs_pix[i].f} === {exp_pix[i].v, exp_pix[i].f}) else begin
        n_err++;
        $error("FAIL %s pix[%0d] valid/frame: got %b%b expected %b%b", tag, i,
               obs_pix[i].v, obs_pix[i].f, exp_pix[i].v, exp_pix[i].f);
      end
      if (exp_pix[i].v) begin
        n_cmp++;
        assert ({obs_pix[i].pix, obs_pix[i].h, obs_pix[i].vv} ===
                {exp_pix[i].pix, exp_pix[i].h, exp_pix[i].vv}) else begin
          n_err++;
          $error("FAIL %s pix[%0d] data: got %h@(%0d,%0d) expected %h@(%0d,%0d)", tag, i,
                 obs_pix[i].pix, obs_pix[i].h, obs_pix[i].vv,
                 exp_pix[i].pix, exp_pix[i].h, exp_pix[i].vv);
        end
      end
    end
    obs_cmd.delete(); exp_cmd.delete();
    obs_pix.delete(); exp_pix.delete();
  endtask

  initial begin
    pev_t ref_e;
    int   s, e, op;
    in_rst = 1'b0; in_vid_rst = 1'b0; in_vid_select = 1'b0; in_vid_cmd = 1'b0;
    in_vid_serial_clk = 1'b0; in_vid_serial = 1'b0;
    model_reset();
    repeat (3) @(negedge in_clk);
    n_cmp++;
    assert ({out_cmd_valid, out_pix_valid, out_frame} === 3'b000) else begin
      n_err++;
      $error("FAIL reset_pulses: got %b expected 000", {out_cmd_valid, out_pix_valid, out_frame});
    end
    n_cmp++;
    assert ({out_cmd, out_pixel, out_hpix, out_vpix} === 40'd0) else begin
      n_err++;
      $error("FAIL reset_data: got %h expected 0", {out_cmd, out_pixel, out_hpix, out_vpix});
    end
    in_rst = 1'b1;
    repeat (2) @(negedge in_clk);
    in_vid_select = 1'b1;

    // Single pixel with the default window.
    send_byte(1'b1, 'h2C); send_byte(1'b0, 'hF8); send_byte(1'b0, 'h00);
    repeat (12) @(negedge in_clk);
    ref_e = {1'b1, 16'hF800, 8'd0, 8'd0, 1'b0};
    n_cmp++;
    assert (obs_pix.size() === 1 && obs_pix[0] === ref_e) else begin
      n_err++;
      $error("FAIL first_pixel: got %0d events expected one F800 at (0,0)", obs_pix.size());
    end
    check_events("first_pixel_stream");

    // Two-column single-row window with wrap and frame pulses.
    send_win('h2A, 40, 41); send_win('h2B, 55, 55); send_pixels(4);
    check_events("small_window");

    // Off-screen window.
    send_win('h2A, 0, 1); send_pixels(3);
    check_events("offscreen");

    // Aborted partial word followed by a command.
    send_bits(1'b1, 8'hAB, 5);
    in_vid_select = 1'b0; #100 in_vid_select = 1'b1; #20;
    send_byte(1'b1, 'h2C);
    check_events("select_abort");

    // Panel reset in the middle of a memory write.
    send_pixels(1); send_byte(1'b0, 'h12);
    @(negedge in_clk) in_vid_rst = 1'b1;
    repeat (3) @(negedge in_clk);
    in_vid_rst = 1'b0;
    model_reset();
    send_byte(1'b0, 'h34); send_byte(1'b0, 'h56);
    send_pixels(2);
    check_events("vid_rst");

    // Unknown command with data bytes.
    send_byte(1'b1, 'h11); send_byte(1'b0, 'h2A); send_byte(1'b0, 'h2B);
    send_pixels(1);
    check_events("other_cmd");

    // Randomized traffic around the visible-area edges.
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 4);
      if (op == 0 || op == 1) begin
        s = (op == 0) ? $urandom_range(HO - 3, HO + W) : $urandom_range(VO - 3, VO + H);
        e = s + $urandom_range(0, 4) - 1;
        send_win((op == 0) ? 'h2A : 'h2B, s, e);
      end else if (op == 2) begin
        send_pixels($urandom_range(1, 8));
      end else if (op == 3) begin
        send_byte(1'b1, $urandom_range(0, 255) | 'h80);
        for (int k = 0; k < $urandom_range(0, 2); k++) send_byte(1'b0, $urandom_range(0, 255));
      end else begin
        send_byte(1'b1, 'h2A);
        send_byte(1'b0, $urandom_range(0, 255));
        send_bits(1'b0, 8'($urandom_range(0, 255)), $urandom_range(1, 7));
        in_vid_select = 1'b0; #100 in_vid_select = 1'b1; #20;
        send_pixels(2);
      end
      check_events("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
